// File: rtl/regfile_scoreboard.sv
// Register file with a hardwired-zero entry, two combinational read ports, one
// write port, optional same-cycle write forwarding and a pending-write scoreboard.
module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_pend_a,
  output logic              rd_pend_b,
  output logic              stall,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  pend_vec
);

  logic             wrValid;
  logic             rsvValid;
  logic [WIDTH-1:0] regData [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // True for indices that name a real, writable register.
  function automatic logic isReal(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
  endfunction

  function automatic logic [WIDTH-1:0] readData(input logic [ADDR_W-1:0] a);
    if (!isReal(a)) return '0;
    if (BYPASS && wrValid && (wr_addr == a)) return wr_data;
    return regData[a];
  endfunction

  // A forwarded write is final unless a new reservation lands on the same index.
  function automatic logic readPend(input logic [ADDR_W-1:0] a);
    if (!isReal(a)) return 1'b0;
    if (BYPASS && wrValid && (wr_addr == a) && !(rsvValid && (rsv_addr == a)))
      return 1'b0;
    return pend_q[a];
  endfunction

  assign wrValid  = wr_en && isReal(wr_addr);
  assign rsvValid = rsv_en && isReal(rsv_addr);

  for (genvar i = 0; i < DEPTH; i++) begin : gReg
    if (i == ZERO_REG) begin : gZero
      assign regData[i] = '0;
    end else begin : gStore
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;

      always_comb begin
        data_d = data_q;
        if (wrValid && (wr_addr == ADDR_W'(i))) data_d = wr_data;
      end

      always_ff @(posedge clk) begin
        if (!reset) data_q <= '0;
        else        data_q <= data_d;
      end

      assign regData[i] = data_q;
    end
  end

  // Reservation is applied after the clear so that set wins on a collision.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wrValid && (int'(wr_addr) == i))   pend_d[i] = 1'b0;
      if (rsvValid && (int'(rsv_addr) == i)) pend_d[i] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    rd_data_a = readData(rd_addr_a);
    rd_data_b = readData(rd_addr_b);
    rd_pend_a = readPend(rd_addr_a);
    rd_pend_b = readPend(rd_addr_b);
    stall     = rd_pend_a | rd_pend_b;
  end

  assign pend_vec = pend_q;

endmodule
